seq_right_shifter32: RTL and testbench

- Multi-cycle 32-bit right shifter for the 32-bit ALU datapath.
- Covers the opposite direction to the existing combinational left shifter.
- Applies one barrel stage per clock: stage k shifts by 2^k when shAmt bit k is set.
- Supports logical shifts (zero fill) and arithmetic shifts (sign fill).
- Uses a start/busy/done handshake so the ALU control FSM can issue SRL/SRA and wait for completion.

---
 rtl/seq_right_shifter32.sv | 83 ++++++++
 tb/tb_seq_right_shifter32.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/seq_right_shifter32.sv
// Multi-cycle right shifter: one barrel stage per clock, logical or arithmetic fill.
// start/busy/done handshake; fixed latency of SHW stage cycles whatever the shift amount.
module seq_right_shifter32 #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] in,
  input  logic [SHW-1:0]   shAmt,
  input  logic             arith,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out
);

  localparam int KW = (SHW > 1) ? $clog2(SHW) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] data;
  logic [SHW-1:0]   amt;
  logic             fill;
  logic [KW-1:0]    k;

  logic             accept;
  logic             last_stage;
  logic [SHW:0]     stage_dist;
  logic [WIDTH:0]   shifted_ext;
  logic [WIDTH-1:0] data_next;

  assign accept     = start && (state != SHIFT);
  assign last_stage = (k == KW'(SHW - 1));
  assign stage_dist = (SHW + 1)'(1) << k;

  // Prepending the fill bit lets a signed shift supply the fill for any stage distance.
  assign shifted_ext = $signed({fill, data}) >>> stage_dist;
  assign data_next   = amt[k] ? shifted_ext[WIDTH-1:0] : data;

  assign busy = (state == SHIFT);
  assign done = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = SHIFT;
      SHIFT:   if (last_stage) state_next = DONE;
      DONE:    state_next = accept ? SHIFT : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data <= '0;
      amt  <= '0;
      fill <= 1'b0;
      k    <= '0;
      out  <= '0;
    end else if (accept) begin
      data <= in;
      amt  <= shAmt;
      fill <= arith & in[WIDTH-1];
      k    <= '0;
    end else if (state == SHIFT) begin
      data <= data_next;
      k    <= k + KW'(1);
      if (last_stage) out <= data_next;
    end
  end

endmodule

// File: tb/tb_seq_right_shifter32.sv
// Self-checking bench for seq_right_shifter32: directed vector table, handshake corner
// sequences and a randomized sweep against a plain-arithmetic shift model.
module tb_seq_right_shifter32;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] din;
  logic [4:0]  sh;
  logic        arith;
  logic        busy;
  logic        done;
  logic [31:0] out;

  int checks = 0;
  int failures = 0;

  seq_right_shifter32 dut (
    .clk(clk), .rst(rst), .start(start), .in(din), .shAmt(sh),
    .arith(arith), .busy(busy), .done(done), .out(out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [4:0]  s;
    logic        ar;
    logic [31:0] exp;
  } vec_t;

  function automatic logic [31:0] model(input logic [31:0] a, input logic [4:0] s, input logic ar);
    if (ar) return 32'($signed(a) >>> s);
    return a >> s;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Called at posedge+1 with the DUT idle or in its done cycle; returns in the done cycle.
  // lat = edges after the start edge until done is seen (-1 on timeout).
  task automatic run_op(input logic [31:0] a, input logic [4:0] s, input logic ar,
                        output int lat, output logic bad_ctl);
    logic [31:0] out_hold;
    din = a; sh = s; arith = ar; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    bad_ctl = 1'b0;
    out_hold = out;
    if (!busy || done) bad_ctl = 1'b1;
    for (int c = 1; c <= 12 && lat < 0; c++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = c;
        if (busy) bad_ctl = 1'b1;
      end else if (!busy || out !== out_hold) begin
        bad_ctl = 1'b1;
      end
    end
  endtask

  vec_t vecs[6];
  int lat;
  logic bad;
  int t0;
  int seen;

  initial begin
    vecs[0] = '{32'h8000_00F0, 5'd4,  1'b0, 32'h0800_000F};
    vecs[1] = '{32'h8000_00F0, 5'd4,  1'b1, 32'hF800_000F};
    vecs[2] = '{32'h8000_0000, 5'd31, 1'b1, 32'hFFFF_FFFF};
    vecs[3] = '{32'h8000_0000, 5'd31, 1'b0, 32'h0000_0001};
    vecs[4] = '{32'hDEAD_BEEF, 5'd0,  1'b1, 32'hDEAD_BEEF};
    vecs[5] = '{32'h7FFF_0000, 5'd16, 1'b1, 32'h0000_7FFF};

    rst = 1'b1; start = 1'b0; din = '0; sh = '0; arith = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_out", out, 32'h0);
    check("reset_busy", {31'b0, busy}, 32'h0);
    check("reset_done", {31'b0, done}, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].s, vecs[i].ar, lat, bad);
      check($sformatf("vec%0d_out", i), out, vecs[i].exp);
      check($sformatf("vec%0d_latency", i), lat, 5);
      check($sformatf("vec%0d_handshake", i), {31'b0, bad}, 32'h0);
      @(posedge clk); #1;
    end

    // Back-to-back issue in the done cycle: second done 6 cycles after the first.
    run_op(32'h8000_00F0, 5'd4, 1'b0, lat, bad);
    t0 = int'($time);
    run_op(32'h0000_0100, 5'd8, 1'b0, lat, bad);
    check("b2b_spacing", (int'($time) - t0) / 10, 6);
    check("b2b_out", out, 32'h0000_0001);
    check("b2b_handshake", {31'b0, bad}, 32'h0);
    @(posedge clk); #1;

    // start pulse while busy must be ignored and not queued.
    din = 32'h0000_0100; sh = 5'd8; arith = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    din = 32'hFFFF_FFFF; sh = 5'd0; arith = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      if (done) seen++;
      @(posedge clk); #1;
    end
    check("busy_start_done_count", seen, 1);
    check("busy_start_out", out, 32'h0000_0001);

    // Async reset during stage 2 abandons the operation.
    din = 32'hF000_0000; sh = 5'd7; arith = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("midrst_out", out, 32'h0);
    check("midrst_busy", {31'b0, busy}, 32'h0);
    check("midrst_done", {31'b0, done}, 32'h0);
    #2 rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (done || busy) seen++;
    end
    check("midrst_no_done", seen, 0);
    run_op(32'h0000_0010, 5'd1, 1'b0, lat, bad);
    check("after_rst_out", out, 32'h0000_0008);
    check("after_rst_latency", lat, 5);

    // Randomized sweep; consecutive ops issue back-to-back from the done cycle.
    for (int i = 0; i < 1000; i++) begin
      logic [31:0] a;
      logic [4:0]  s;
      logic        ar;
      a  = $urandom;
      s  = 5'($urandom_range(0, 31));
      ar = 1'($urandom_range(0, 1));
      run_op(a, s, ar, lat, bad);
      check($sformatf("rand%0d_out", i), out, model(a, s, ar));
      check($sformatf("rand%0d_latency", i), lat, 5);
      check($sformatf("rand%0d_handshake", i), {31'b0, bad}, 32'h0);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
